// File: rtl/ram_bus_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_sampler_pkg
// Description : Shared PSRAM bus widths, pin polarities, bus record and
//               control decode for the RAM tracer front end.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_bus_sampler_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam int c_SYNC_STAGES_DEF = 2;

  // Asserted level of each control pin
  localparam logic c_CE1_ACTIVE = 1'b0;
  localparam logic c_CE2_ACTIVE = 1'b1;
  localparam logic c_OE_ACTIVE  = 1'b0;
  localparam logic c_WE_ACTIVE  = 1'b0;
  localparam logic c_UB_ACTIVE  = 1'b0;
  localparam logic c_LB_ACTIVE  = 1'b0;
  localparam logic c_ADV_ACTIVE = 1'b0;

  // One snapshot of every bus pin except ram_clk
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              oe;
    logic              we;
    logic              ce1;
    logic              ce2;
    logic              ub;
    logic              lb;
    logic              adv;
  } bus_t;

  typedef struct packed {
    logic       read;
    logic       write;
    logic       addr_latch;
    logic [1:0] ublb;
  } decode_t;

  // Byte enables follow the pins regardless of chip select; the
  // access-type flags only fire while the chip is selected.
  function automatic decode_t decode_bus(input bus_t b);
    decode_t r;
    logic    sel;
    sel          = (b.ce1 == c_CE1_ACTIVE) && (b.ce2 == c_CE2_ACTIVE);
    r.read       = sel && (b.oe == c_OE_ACTIVE) && (b.we != c_WE_ACTIVE);
    r.write      = sel && (b.we == c_WE_ACTIVE);
    r.addr_latch = sel && (b.adv == c_ADV_ACTIVE);
    r.ublb       = {b.ub == c_UB_ACTIVE, b.lb == c_LB_ACTIVE};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bus_sampler_sync_deglitch.sv
`default_nettype none
// ============================================================================
// Module      : sync_deglitch
// Description : Single-bit synchronizer followed by a run-length filter.
//               The accepted level flips only after CLK_FILTER consecutive
//               synchronized samples disagree with it.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_deglitch #(
  parameter int SYNC_STAGES = 2,
  parameter int CLK_FILTER  = 2
) (
  input  logic mclk,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam int                 c_CNT_W    = $clog2(CLK_FILTER) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_FILTER - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_level;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];
  assign level    = r_level;

  // Synchronize the raw pin, then count disagreeing samples and flip the
  // accepted level on the CLK_FILTER-th one in a row.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_sampler
// Description : RAM tracer front end. Synchronizes the raw PSRAM pins into
//               mclk, deglitches ram_clk and emits one-cycle strobes with
//               the decoded bus on accepted rising and falling edges.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bus_sampler
  import ram_bus_sampler_pkg::*;
#(
  parameter int SYNC_STAGES = c_SYNC_STAGES_DEF,
  parameter int CLK_FILTER  = 2
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_a,
  input  logic [DATA_W-1:0] ram_d,
  input  logic              ram_oe,
  input  logic              ram_we,
  input  logic              ram_ce1_in,
  input  logic              ram_ub,
  input  logic              ram_lb,
  input  logic              ram_adv,
  input  logic              ram_ce2,
  input  logic              ram_clk,
  output logic [ADDR_W-1:0] filter_a,
  output logic [DATA_W-1:0] filter_d,
  output logic [1:0]        filter_ublb,
  output logic              filter_read,
  output logic              filter_write,
  output logic              filter_addr_latch,
  output logic              filter_strobe,
  output logic [DATA_W-1:0] nfilter_d,
  output logic              nfilter_strobe
);

  // The accepted clock level moves CLK_FILTER cycles after the synchronized
  // clock, so the sample taken just before the synchronized clock changed
  // sits CLK_FILTER+1 entries back (index CLK_FILTER) when the strobe is
  // registered.
  localparam int c_HIST_DEPTH = CLK_FILTER + 1;

  bus_t    w_bus_pins;
  bus_t    r_bus_sync [SYNC_STAGES];
  bus_t    r_hist     [c_HIST_DEPTH];
  bus_t    w_hist_out;
  decode_t w_dec;
  logic    w_clk_level;
  logic    r_clk_level_d;
  logic    w_rise;
  logic    w_fall;

  assign w_bus_pins.a   = ram_a;
  assign w_bus_pins.d   = ram_d;
  assign w_bus_pins.oe  = ram_oe;
  assign w_bus_pins.we  = ram_we;
  assign w_bus_pins.ce1 = ram_ce1_in;
  assign w_bus_pins.ce2 = ram_ce2;
  assign w_bus_pins.ub  = ram_ub;
  assign w_bus_pins.lb  = ram_lb;
  assign w_bus_pins.adv = ram_adv;

  // ram_clk synchronizer shares the bus synchronizer depth to stay aligned
  sync_deglitch #(
    .SYNC_STAGES (SYNC_STAGES),
    .CLK_FILTER  (CLK_FILTER)
  ) u_clk_deglitch (
    .mclk  (mclk),
    .reset (reset),
    .din   (ram_clk),
    .level (w_clk_level)
  );

  // Bus synchronizer chain followed by the sample history (entry 0 = prev)
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_bus_sync[i] <= '0;
      end
      for (int i = 0; i < c_HIST_DEPTH; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_bus_sync[0] <= w_bus_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_bus_sync[i] <= r_bus_sync[i-1];
      end
      r_hist[0] <= r_bus_sync[SYNC_STAGES-1];
      for (int i = 1; i < c_HIST_DEPTH; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  assign w_hist_out = r_hist[CLK_FILTER];
  assign w_dec      = decode_bus(w_hist_out);
  assign w_rise     = w_clk_level && !r_clk_level_d;
  assign w_fall     = !w_clk_level && r_clk_level_d;

  // Edge strobes and captured bus state; captures hold between edges
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_clk_level_d     <= 1'b0;
      filter_strobe     <= 1'b0;
      nfilter_strobe    <= 1'b0;
      filter_a          <= '0;
      filter_d          <= '0;
      filter_ublb       <= '0;
      filter_read       <= 1'b0;
      filter_write      <= 1'b0;
      filter_addr_latch <= 1'b0;
      nfilter_d         <= '0;
    end else begin
      r_clk_level_d  <= w_clk_level;
      filter_strobe  <= w_rise;
      nfilter_strobe <= w_fall;
      if (w_rise) begin
        filter_a          <= w_hist_out.a;
        filter_d          <= w_hist_out.d;
        filter_ublb       <= w_dec.ublb;
        filter_read       <= w_dec.read;
        filter_write      <= w_dec.write;
        filter_addr_latch <= w_dec.addr_latch;
      end
      if (w_fall) begin
        nfilter_d <= w_hist_out.d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bus_sampler
// Description : Scoreboard bench for ram_bus_sampler. Directed ram_clk
//               phases push expected strobes; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bus_sampler;

  logic        mclk  = 1'b0;
  logic        reset = 1'b0;
  logic [22:0] ram_a = '0;
  logic [15:0] ram_d = '0;
  logic        ram_oe = 1'b1, ram_we = 1'b1, ram_ce1_in = 1'b1;
  logic        ram_ub = 1'b1, ram_lb = 1'b1, ram_adv = 1'b1;
  logic        ram_ce2 = 1'b0, ram_clk = 1'b0;

  logic [22:0] filter_a;
  logic [15:0] filter_d;
  logic [1:0]  filter_ublb;
  logic        filter_read, filter_write, filter_addr_latch, filter_strobe;
  logic [15:0] nfilter_d;
  logic        nfilter_strobe;

  ram_bus_sampler #(
    .SYNC_STAGES (2),
    .CLK_FILTER  (2)
  ) dut (
    .mclk              (mclk),
    .reset             (reset),
    .ram_a             (ram_a),
    .ram_d             (ram_d),
    .ram_oe            (ram_oe),
    .ram_we            (ram_we),
    .ram_ce1_in        (ram_ce1_in),
    .ram_ub            (ram_ub),
    .ram_lb            (ram_lb),
    .ram_adv           (ram_adv),
    .ram_ce2           (ram_ce2),
    .ram_clk           (ram_clk),
    .filter_a          (filter_a),
    .filter_d          (filter_d),
    .filter_ublb       (filter_ublb),
    .filter_read       (filter_read),
    .filter_write      (filter_write),
    .filter_addr_latch (filter_addr_latch),
    .filter_strobe     (filter_strobe),
    .nfilter_d         (nfilter_d),
    .nfilter_strobe    (nfilter_strobe)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          fall;
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0]  ublb;
    logic        rd;
    logic        wr;
    logic        al;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t none_e;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic exp_t mk_rise(input logic [22:0] a, input logic [15:0] d,
                                   input logic [1:0] ublb, input logic rd,
                                   input logic wr, input logic al);
    exp_t e;
    e.fall = 1'b0; e.a = a; e.d = d; e.ublb = ublb;
    e.rd = rd; e.wr = wr; e.al = al; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t mk_fall(input logic [15:0] nd);
    exp_t e;
    e = mk_rise('0, nd, 2'b00, 1'b0, 1'b0, 1'b0);
    e.fall = 1'b1;
    return e;
  endfunction

  // One ram_clk phase of n mclk cycles; optionally changes the address on
  // the same cycle as the clock edge. Expected strobe lands 5 cycles later.
  task automatic phase(input logic lvl, input int n, input bit exp_en, input exp_t e,
                       input bit chg_a, input logic [22:0] na);
    @(negedge mclk);
    ram_clk = lvl;
    if (chg_a) ram_a = na;
    if (exp_en) begin
      e.cyc  = cyc + 5;
      e.fall = !lvl;
      sb.push_back(e);
    end
    repeat (n - 1) @(negedge mclk);
  endtask

  task automatic rise(input int n, input exp_t e);
    phase(1'b1, n, 1'b1, e, 1'b0, '0);
  endtask

  task automatic fall(input int n, input exp_t e);
    phase(1'b0, n, 1'b1, e, 1'b0, '0);
  endtask

  task automatic idle_phase(input logic lvl, input int n);
    phase(lvl, n, 1'b0, none_e, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_filter_strobe"}, 32'(filter_strobe), 0);
    chk({tag, "_nfilter_strobe"}, 32'(nfilter_strobe), 0);
    chk({tag, "_filter_a"}, 32'(filter_a), 0);
    chk({tag, "_filter_d"}, 32'(filter_d), 0);
    chk({tag, "_filter_ublb"}, 32'(filter_ublb), 0);
    chk({tag, "_flags"}, 32'({filter_read, filter_write, filter_addr_latch}), 0);
    chk({tag, "_nfilter_d"}, 32'(nfilter_d), 0);
  endtask

  // Monitor: every strobe pops one expectation and is compared against it
  initial begin : monitor
    exp_t e;
    exp_t held;
    held = mk_rise('0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    forever begin
      @(posedge mclk);
      #1;
      if (filter_strobe || nfilter_strobe) begin
        chk("strobe_overlap", 32'(filter_strobe & nfilter_strobe), 0);
        chk("strobe_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("edge_kind", 32'(nfilter_strobe), 32'(e.fall));
          chk("latency", 32'(cyc), 32'(e.cyc));
          if (!e.fall) begin
            chk("rise_a", 32'(filter_a), 32'(e.a));
            chk("rise_d", 32'(filter_d), 32'(e.d));
            chk("rise_ublb", 32'(filter_ublb), 32'(e.ublb));
            chk("rise_read", 32'(filter_read), 32'(e.rd));
            chk("rise_write", 32'(filter_write), 32'(e.wr));
            chk("rise_addr_latch", 32'(filter_addr_latch), 32'(e.al));
            held = e;
          end else begin
            chk("fall_nd", 32'(nfilter_d), 32'(e.d));
            chk("fall_hold_a", 32'(filter_a), 32'(held.a));
            chk("fall_hold_write", 32'(filter_write), 32'(held.wr));
            chk("fall_hold_read", 32'(filter_read), 32'(held.rd));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    none_e = mk_rise('0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    repeat (3) @(negedge mclk);
    #1;
    check_zero("reset");
    @(negedge mclk);
    reset = 1'b0;

    // Write burst: address phase, then data phase
    ram_ce1_in = 1'b0; ram_ce2 = 1'b1; ram_adv = 1'b0; ram_a = 23'h123456;
    ram_ub = 1'b0; ram_lb = 1'b0;
    idle_phase(1'b0, 4);
    rise(3, mk_rise(23'h123456, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1));
    ram_adv = 1'b1; ram_we = 1'b0; ram_d = 16'hBEEF;
    fall(3, mk_fall(16'hBEEF));
    rise(3, mk_rise(23'h123456, 16'hBEEF, 2'b11, 1'b0, 1'b1, 1'b0));
    fall(3, mk_fall(16'hBEEF));

    // Read burst: data changes during the high phase
    ram_oe = 1'b0; ram_we = 1'b1; ram_d = 16'h55AA;
    rise(4, mk_rise(23'h123456, 16'h55AA, 2'b11, 1'b1, 1'b0, 1'b0));
    ram_d = 16'hA55A;
    fall(3, mk_fall(16'hA55A));

    // Glitch rejection: 1-cycle pulse ignored, 3-cycle pulse accepted
    idle_phase(1'b0, 3);
    idle_phase(1'b1, 1);
    idle_phase(1'b0, 4);
    rise(3, mk_rise(23'h123456, 16'hA55A, 2'b11, 1'b1, 1'b0, 1'b0));
    fall(4, mk_fall(16'hA55A));

    // Deselect: strobes continue, flags off, byte enables follow pins
    ram_ce2 = 1'b0; ram_ub = 1'b0; ram_lb = 1'b1; ram_oe = 1'b0;
    ram_we = 1'b0; ram_adv = 1'b0; ram_a = 23'h7FFFFF; ram_d = 16'h1234;
    rise(3, mk_rise(23'h7FFFFF, 16'h1234, 2'b10, 1'b0, 1'b0, 1'b0));
    fall(3, mk_fall(16'h1234));

    // Address changes on the same cycle as the clock rise: old value wins
    phase(1'b1, 3, 1'b1, mk_rise(23'h7FFFFF, 16'h1234, 2'b10, 1'b0, 1'b0, 1'b0),
          1'b1, 23'h000001);
    fall(6, mk_fall(16'h1234));

    // Reset mid-stream during a high phase with an edge in the pipeline
    idle_phase(1'b1, 2);
    @(negedge mclk);
    reset   = 1'b1;
    ram_clk = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    ram_ce2 = 1'b1; ram_oe = 1'b1; ram_we = 1'b0; ram_adv = 1'b1;
    ram_ub = 1'b0; ram_lb = 1'b0; ram_a = 23'h2AAAAA; ram_d = 16'hC3C3;
    idle_phase(1'b0, 3);
    rise(3, mk_rise(23'h2AAAAA, 16'hC3C3, 2'b11, 1'b0, 1'b1, 1'b0));
    fall(3, mk_fall(16'hC3C3));

    // Drain, with a bounded wait for the last expected strobes
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge mclk);
    repeat (4) @(negedge mclk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
